// File: rtl/divider_sched.sv
// Round-robin scheduler in front of one shared restoring divider (one quotient bit per cycle).
// Optional macro DIVIDER_SCHED_DIVZERO_EN: a zero divisor skips the iterations and completes right after grant.
module divider_sched #(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_cg,
   input  logic [N_REQ-1:0]       i_req_valid,
   output logic [N_REQ-1:0]       o_req_ready,
   input  logic [N_REQ*WIDTH-1:0] i_dividend,
   input  logic [N_REQ*WIDTH-1:0] i_divisor,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [ID_W-1:0]        o_rsp_id,
   output logic [WIDTH-1:0]       o_quotient,
   output logic [WIDTH-1:0]       o_remainder,
   output logic                   o_divzero,
   output logic                   o_busy,
   output logic [1:0]             o_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready && i_cg && i_rst.
   // Requesters hold valid and operands until their ready bit is seen; the result holds until i_rsp_ready.

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  divisor_q;
   logic [WIDTH-1:0]  quo_q;
   logic [WIDTH-1:0]  rem_q;
   logic [ID_W-1:0]   id_q;
   logic              dz_q;

   logic              found;
   logic [ID_W-1:0]   gnt_id;
   logic              grant_ok;
   logic [WIDTH-1:0]  a_sel;
   logic [WIDTH-1:0]  b_sel;
   logic [WIDTH:0]    partial;
   logic [WIDTH:0]    trial;
   logic              take;

   // First valid requester at or after ptr, wrapping around.
   always_comb begin
      int c;
      found  = 1'b0;
      gnt_id = '0;
      c      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         c = int'(ptr) + i;
         if (c >= N_REQ) c = c - N_REQ;
         if (!found && i_req_valid[c[ID_W-1:0]]) begin
            found  = 1'b1;
            gnt_id = c[ID_W-1:0];
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt_id == ID_W'(k)) begin
            a_sel = i_dividend[k*WIDTH +: WIDTH];
            b_sel = i_divisor[k*WIDTH +: WIDTH];
         end
      end
   end

   assign grant_ok = (state == S_IDLE) && i_cg && i_rst && found;

   always_comb begin
      o_req_ready = '0;
      if (grant_ok) o_req_ready = N_REQ'(1) << gnt_id;
   end

   // Trial subtraction one bit wider than the operands so the borrow is the sign.
   assign partial = {rem_q, quo_q[WIDTH-1]};
   assign trial   = partial - {1'b0, divisor_q};
   assign take    = ~trial[WIDTH];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         cnt       <= '0;
         divisor_q <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         id_q      <= '0;
         dz_q      <= 1'b0;
      end else if (i_cg) begin
         case (state)
            S_IDLE: begin
               if (grant_ok) begin
                  id_q      <= gnt_id;
                  divisor_q <= b_sel;
                  dz_q      <= (b_sel == '0);
                  ptr       <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
                  cnt       <= CNT_W'(WIDTH);
`ifdef DIVIDER_SCHED_DIVZERO_EN
                  if (b_sel == '0) begin
                     quo_q <= '1;
                     rem_q <= a_sel;
                     cnt   <= '0;
                     state <= S_DONE;
                  end else begin
                     quo_q <= a_sel;
                     rem_q <= '0;
                     state <= S_CALC;
                  end
`else
                  quo_q <= a_sel;
                  rem_q <= '0;
                  state <= S_CALC;
`endif
               end
            end
            S_CALC: begin
               // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
               quo_q <= {quo_q[WIDTH-2:0], take};
               rem_q <= take ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
               cnt   <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= S_DONE;
            end
            S_DONE: begin
               if (i_rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_rsp_valid = (state == S_DONE);
   assign o_busy      = (state != S_IDLE);
   assign o_state     = state;
   assign o_rsp_id    = id_q;
   assign o_quotient  = quo_q;
   assign o_remainder = rem_q;
   assign o_divzero   = dz_q;

endmodule
